surf_wb_arbiter: RTL
====================

Name: surf_wb_arbiter

Overview:
- 2:1 round-robin Wishbone arbiter feeding the SURF ID/control register target.
- The two requesters are m0, the TURF command path, and m1, the local debug/serial master.
- A per-transaction timeout converts a hung target into an error response, so neither master can lock the bus.
- Sits directly upstream of the ID/control target, in the wishbone clock domain.

Parameters:
ADR_BITS, 11, Wishbone address width passed through.
TIMEOUT_CYCLES, 255, cycles of cyc&stb without any response before abort; 0 disables timeout.
TO_CNT_BITS, 8, width of the saturating timeout event counter.

Ports:
wb_clk_i  input  1  Wishbone clock.
wb_rst_n_i  input  1  Reset: synchronous, active-low.
m{0,1}_cyc_i  input  1  Master cycle.
m{0,1}_stb_i  input  1  Master strobe.
m{0,1}_we_i  input  1  Master write enable.
m{0,1}_adr_i  input  ADR_BITS  Master address.
m{0,1}_dat_i  input  32  Master write data.
m{0,1}_sel_i  input  4  Master byte selects.
m{0,1}_dat_o  output  32  Read data; slave data when granted, else 0.
m{0,1}_ack_o  output  1  Ack to master.
m{0,1}_err_o  output  1  Error to master (slave err or timeout).
m{0,1}_rty_o  output  1  Retry to master.
s_cyc_o  output  1  Slave cycle.
s_stb_o  output  1  Slave strobe.
s_we_o  output  1  Slave write enable.
s_adr_o  output  ADR_BITS  Slave address.
s_dat_o  output  32  Slave write data.
s_sel_o  output  4  Slave byte selects.
s_dat_i  input  32  Slave read data.
s_ack_i  input  1  Slave ack.
s_err_i  input  1  Slave error.
s_rty_i  input  1  Slave retry.
grant_o  output  2  One-hot current grant, 00 when idle.
timeout_count_o  output  TO_CNT_BITS  Saturating count of timeout aborts.

Behaviour:
- Reset (wb_rst_n_i=0 at clock edge):
  - State=IDLE, last_grant=1, timeout counter=0, timeout_count_o=0.
  - All s_* and m*_ outputs 0.
  - Reset mid-transaction drops s_cyc_o on the next edge and issues no response.
- States: IDLE, GNT0, GNT1, ABORT.
- IDLE arbitration on registered state:
  - Only m0_cyc_i → GNT0. Only m1_cyc_i → GNT1.
  - Both → grant the master other than last_grant; m0 wins the first contention after reset.
  - On entering a GNT state, last_grant is updated and the timeout counter is cleared.
- Grant latency: 1 cycle. s_cyc_o is 0 in IDLE; the request appears on s_* the cycle after cyc is seen.
- GNTn:
  - s_cyc/stb/we/adr/dat/sel are combinationally the granted master's signals.
  - Granted master gets s_dat_i, s_ack_i, s_err_i and s_rty_i combinationally.
  - The non-granted master sees dat_o=0 and ack/err/rty=0.
  - grant_o is one-hot.
  - The grant is held across multiple strobes while the granted master's cyc stays high.
  - When the granted cyc falls → IDLE, leaving one idle cycle before any re-grant.
- Timeout (TIMEOUT_CYCLES>0):
  - In GNTn, the counter increments each cycle with cyc&stb and no ack/err/rty; it clears on any response.
  - When counter==TIMEOUT_CYCLES-1 and still no response, the next cycle is abort:
    - m{n}_err_o=1 for exactly 1 cycle; s_cyc_o and s_stb_o forced 0 that cycle.
    - timeout_count_o increments, saturating at all-ones.
    - State → ABORT.
- ABORT:
  - s_cyc_o=0; the master sees no responses.
  - Late slave responses are discarded.
  - Stays in ABORT until the aborted master's cyc=0 → IDLE.
- Simultaneous events:
  - Slave ack in the same cycle the timeout would fire: the ack wins, with no err and no count.
  - Master drops cyc in the same cycle as ack: normal completion, → IDLE.
- Pending other master: waits in IDLE/GNT with no responses; no starvation, because it is guaranteed the next grant once contention resolves.

Test Plan:
- Single m0 read at adr 0x004, slave acks 1 cycle after stb → s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o with m0_dat_o=slave data; m1 outputs stay 0; grant_o=01 then 00.
- m0 and m1 assert cyc in the same cycle, each doing 1 write, repeated 4 times → grants alternate 01,10,01,10; each master's writes reach s_* with correct adr/dat/sel.
- m1 holds cyc across 3 back-to-back strobes while m0 requests → all 3 m1 transfers complete before grant_o=01.
- TIMEOUT_CYCLES=8, slave never acks → m0_err_o pulses 1 cycle 8 cycles after stb; s_cyc_o=0 from then on; timeout_count_o=1; a late s_ack_i is not forwarded; IDLE after m0 drops cyc.
- Ack arriving exactly on the timeout cycle → m0_ack_o=1, m0_err_o=0, timeout_count_o unchanged. Drive 300 timeouts with TO_CNT_BITS=8 → timeout_count_o saturates at 255.
- Assert wb_rst_n_i=0 for 1 cycle mid-GNT1 → next cycle s_cyc_o=0, grant_o=00; next contention grants m0 first.

Source files
------------

// File: rtl/surf_wb_arbiter.sv
// 2:1 round-robin Wishbone arbiter in front of the SURF ID/control target.
// A per-transaction timeout turns a silent target into an error so no master can hold the bus.
module surf_wb_arbiter #(
  parameter int unsigned ADR_BITS       = 11,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TO_CNT_BITS    = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n_i,
  input  logic                   m0_cyc_i,
  input  logic                   m0_stb_i,
  input  logic                   m0_we_i,
  input  logic [ADR_BITS-1:0]    m0_adr_i,
  input  logic [31:0]            m0_dat_i,
  input  logic [3:0]             m0_sel_i,
  output logic [31:0]            m0_dat_o,
  output logic                   m0_ack_o,
  output logic                   m0_err_o,
  output logic                   m0_rty_o,
  input  logic                   m1_cyc_i,
  input  logic                   m1_stb_i,
  input  logic                   m1_we_i,
  input  logic [ADR_BITS-1:0]    m1_adr_i,
  input  logic [31:0]            m1_dat_i,
  input  logic [3:0]             m1_sel_i,
  output logic [31:0]            m1_dat_o,
  output logic                   m1_ack_o,
  output logic                   m1_err_o,
  output logic                   m1_rty_o,
  output logic                   s_cyc_o,
  output logic                   s_stb_o,
  output logic                   s_we_o,
  output logic [ADR_BITS-1:0]    s_adr_o,
  output logic [31:0]            s_dat_o,
  output logic [3:0]             s_sel_o,
  input  logic [31:0]            s_dat_i,
  input  logic                   s_ack_i,
  input  logic                   s_err_i,
  input  logic                   s_rty_i,
  output logic [1:0]             grant_o,
  output logic [TO_CNT_BITS-1:0] timeout_count_o
);

  localparam int unsigned CntW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1, StAbort} state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;   // 0: m0 granted last, 1: m1 granted last
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   abort_q, abort_d;
  logic [TO_CNT_BITS-1:0] to_q, to_d;

  logic gnt0, gnt1, gnt_any, g_cyc, g_stb, resp, timeout_hit, own_cyc;

  assign gnt0    = (state_q == StGnt0);
  assign gnt1    = (state_q == StGnt1);
  assign gnt_any = gnt0 | gnt1;
  assign g_cyc   = gnt1 ? m1_cyc_i : m0_cyc_i;
  assign g_stb   = gnt1 ? m1_stb_i : m0_stb_i;
  assign resp    = s_ack_i | s_err_i | s_rty_i;
  assign own_cyc = last_q ? m1_cyc_i : m0_cyc_i;

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    abort_d = 1'b0;
    to_d    = to_q;
    unique case (state_q)
      StIdle: begin
        if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
          state_d = StGnt0;
          last_d  = 1'b0;
          cnt_d   = '0;
        end else if (m1_cyc_i) begin
          state_d = StGnt1;
          last_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      StGnt0, StGnt1: begin
        if (!g_cyc) begin
          state_d = StIdle;
        end else if (resp) begin
          cnt_d = '0;
        end else if (g_stb) begin
          if (timeout_hit) begin
            state_d = StAbort;
            abort_d = 1'b1;
            to_d    = (&to_q) ? to_q : to_q + TO_CNT_BITS'(1);
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StAbort: begin
        if (!own_cyc) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n_i) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      abort_q <= 1'b0;
      to_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
      to_q    <= to_d;
    end
  end

  always_comb begin
    s_cyc_o  = gnt_any & g_cyc;
    s_stb_o  = gnt_any & g_stb;
    s_we_o   = gnt_any & (gnt1 ? m1_we_i : m0_we_i);
    s_adr_o  = gnt_any ? (gnt1 ? m1_adr_i : m0_adr_i) : '0;
    s_dat_o  = gnt_any ? (gnt1 ? m1_dat_i : m0_dat_i) : '0;
    s_sel_o  = gnt_any ? (gnt1 ? m1_sel_i : m0_sel_i) : '0;
    m0_dat_o = gnt0 ? s_dat_i : '0;
    m0_ack_o = gnt0 & s_ack_i;
    m0_rty_o = gnt0 & s_rty_i;
    // The abort error is a one-cycle pulse to whichever master was last granted.
    m0_err_o = (gnt0 & s_err_i) | ((state_q == StAbort) & abort_q & ~last_q);
    m1_dat_o = gnt1 ? s_dat_i : '0;
    m1_ack_o = gnt1 & s_ack_i;
    m1_rty_o = gnt1 & s_rty_i;
    m1_err_o = (gnt1 & s_err_i) | ((state_q == StAbort) & abort_q & last_q);
    grant_o  = {gnt1, gnt0};
    timeout_count_o = to_q;
  end

endmodule
